// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS program-counter stage.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mips_pkg;

    // Fetch-stage lifecycle: wait after reset, fetch, then park until reset.
    typedef enum logic [1:0] {
        PC_BOOT = 2'd0,
        PC_RUN  = 2'd1,
        PC_HALT = 2'd2
    } pc_state_t;

    // Byte distance between consecutive instruction words.
    localparam int PC_STEP = 4;

    // Default boot address; word aligned.
    localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;

endpackage

// File: rtl/pc_register.sv
// Enable-gated PC storage register with asynchronous reset to the boot address.
// Latency: D captured on the rising Clk edge when En is high; Q is registered.
// Backpressure: En low holds the stored value (used for stall and halt).
module pc_register #(
    parameter int               WIDTH        = 32,
    parameter logic [WIDTH-1:0] RESET_VECTOR = '0
) (
    input  logic             Clk,
    input  logic             R,
    input  logic             En,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q
);

    // Reset forces the boot address immediately; otherwise load when enabled.
    always_ff @(posedge Clk or posedge R) begin
        if (R) begin
            Q <= RESET_VECTOR;
        end else if (En) begin
            Q <= D;
        end
    end

endmodule

// File: rtl/pc_fetch_ctrl.sv
// Program counter and next-PC selection feeding instruction memory, gated by a boot/run/halt FSM.
// Latency: redirects appear on PC one edge after the inputs are sampled; PCPlus4 follows PC combinationally.
// Backpressure: Stall holds PC and overrides Halt and all redirects; BOOT and HALT ignore control inputs.
module pc_fetch_ctrl
    import mips_pkg::*;
#(
    parameter int               WIDTH        = 32,
    parameter logic [WIDTH-1:0] RESET_VECTOR = DEFAULT_RESET_VECTOR,
    parameter int               BOOT_WAIT    = 2
) (
    input  logic             Clk,
    input  logic             R,
    input  logic             Stall,
    input  logic             Branch,
    input  logic             BranchNe,
    input  logic             Zero,
    input  logic             Jump,
    input  logic             JumpReg,
    input  logic             Halt,
    input  logic [WIDTH-1:0] Imm,
    input  logic [25:0]      JIndex,
    input  logic [WIDTH-1:0] RegTarget,
    output logic [WIDTH-1:0] PC,
    output logic [WIDTH-1:0] PCPlus4,
    output logic             FetchValid,
    output logic             Halted,
    output logic             Misaligned
);

    // At least one bit even for BOOT_WAIT=1 so the counter always exists.
    localparam int CNT_W = ($clog2(BOOT_WAIT + 1) < 1) ? 1 : $clog2(BOOT_WAIT + 1);
    localparam logic [CNT_W-1:0] BOOT_LAST = CNT_W'(BOOT_WAIT - 1);

    pc_state_t        state;
    logic [CNT_W-1:0] boot_cnt;

    logic [WIDTH-1:0] pc_next;
    logic [WIDTH-1:0] branch_target;
    logic [WIDTH-1:0] jump_target;
    logic             branch_taken;
    logic             jr_misaligned;
    logic             pc_en;

    // Link value and base for every relative redirect; wraps modulo 2^WIDTH.
    assign PCPlus4 = PC + WIDTH'(PC_STEP);

    // beq takes on Zero, bne takes on ~Zero.
    assign branch_taken  = Branch & (Zero ^ BranchNe);
    assign branch_target = PCPlus4 + (Imm << 2);
    assign jump_target   = {PCPlus4[WIDTH-1:28], JIndex, 2'b00};
    assign jr_misaligned = JumpReg & (RegTarget[1:0] != 2'b00);

    // PC only advances while fetching and not stalled; BOOT and HALT freeze it.
    assign pc_en = (state == PC_RUN) & ~Stall;

    // Next-PC priority: halt, jump-register, jump, taken branch, sequential.
    always_comb begin
        pc_next = PCPlus4;
        if (Halt) begin
            pc_next = PC;
        end else if (JumpReg) begin
            pc_next = jr_misaligned ? PC : RegTarget;
        end else if (Jump) begin
            pc_next = jump_target;
        end else if (branch_taken) begin
            pc_next = branch_target;
        end
    end

    pc_register #(
        .WIDTH        (WIDTH),
        .RESET_VECTOR (RESET_VECTOR)
    ) u_pc_reg (
        .Clk (Clk),
        .R   (R),
        .En  (pc_en),
        .D   (pc_next),
        .Q   (PC)
    );

    // Lifecycle FSM with registered status flags; a bad jr target traps into HALT.
    always_ff @(posedge Clk or posedge R) begin
        if (R) begin
            state      <= PC_BOOT;
            boot_cnt   <= '0;
            FetchValid <= 1'b0;
            Halted     <= 1'b0;
            Misaligned <= 1'b0;
        end else begin
            case (state)
                PC_BOOT: begin
                    if (boot_cnt == BOOT_LAST) begin
                        state      <= PC_RUN;
                        FetchValid <= 1'b1;
                    end else begin
                        boot_cnt <= boot_cnt + 1'b1;
                    end
                end
                PC_RUN: begin
                    if (!Stall) begin
                        if (Halt) begin
                            state      <= PC_HALT;
                            FetchValid <= 1'b0;
                            Halted     <= 1'b1;
                        end else if (jr_misaligned) begin
                            state      <= PC_HALT;
                            FetchValid <= 1'b0;
                            Halted     <= 1'b1;
                            Misaligned <= 1'b1;
                        end
                    end
                end
                PC_HALT: begin
                    state <= PC_HALT;
                end
                default: begin
                    state      <= PC_HALT;
                    FetchValid <= 1'b0;
                    Halted     <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed bench for pc_fetch_ctrl: vector table for next-PC selection, plus hand sequences.
// Latency: each vector is one rising edge; outputs are sampled 1 time unit after the edge.
// Backpressure: Stall vectors check that PC holds.
module tb_pc_fetch_ctrl;

    logic        Clk = 1'b0;
    logic        R;
    logic        Stall, Branch, BranchNe, Zero, Jump, JumpReg, Halt;
    logic [31:0] Imm;
    logic [25:0] JIndex;
    logic [31:0] RegTarget;
    logic [31:0] PC, PCPlus4;
    logic        FetchValid, Halted, Misaligned;

    int n_tests = 0;
    int n_fail  = 0;

    pc_fetch_ctrl #(
        .WIDTH        (32),
        .RESET_VECTOR (32'h0000_0000),
        .BOOT_WAIT    (2)
    ) dut (
        .Clk        (Clk),
        .R          (R),
        .Stall      (Stall),
        .Branch     (Branch),
        .BranchNe   (BranchNe),
        .Zero       (Zero),
        .Jump       (Jump),
        .JumpReg    (JumpReg),
        .Halt       (Halt),
        .Imm        (Imm),
        .JIndex     (JIndex),
        .RegTarget  (RegTarget),
        .PC         (PC),
        .PCPlus4    (PCPlus4),
        .FetchValid (FetchValid),
        .Halted     (Halted),
        .Misaligned (Misaligned)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        string       name;
        logic        stall, branch, bne, zero, jump, jr, halt;
        logic [31:0] imm;
        logic [25:0] jidx;
        logic [31:0] rtgt;
        logic [31:0] exp_pc;
    } vec_t;

    vec_t vecs[17];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        Stall = 0; Branch = 0; BranchNe = 0; Zero = 0; Jump = 0; JumpReg = 0; Halt = 0;
        Imm = '0; JIndex = '0; RegTarget = '0;
    endtask

    // Advance one edge and move to a safe sampling point.
    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    function automatic vec_t mk(input string name, input logic s, input logic b, input logic ne,
                                input logic z, input logic j, input logic jr, input logic h,
                                input logic [31:0] imm, input logic [25:0] jidx,
                                input logic [31:0] rtgt, input logic [31:0] exp_pc);
        vec_t v;
        v.name = name; v.stall = s; v.branch = b; v.bne = ne; v.zero = z; v.jump = j;
        v.jr = jr; v.halt = h; v.imm = imm; v.jidx = jidx; v.rtgt = rtgt; v.exp_pc = exp_pc;
        return v;
    endfunction

    // Release reset and verify the two-edge boot window, driving noise that must be ignored.
    task automatic boot_sequence(input string tag);
        Jump = 1; JIndex = 26'h3FF; Halt = 1;
        check({tag, "_reset_pc"}, PC, 32'h0);
        check({tag, "_reset_fv"}, {31'b0, FetchValid}, 32'd0);
        check({tag, "_reset_halted"}, {31'b0, Halted}, 32'd0);
        check({tag, "_reset_mis"}, {31'b0, Misaligned}, 32'd0);
        R = 0;
        step();
        check({tag, "_boot1_fv"}, {31'b0, FetchValid}, 32'd0);
        check({tag, "_boot1_pc"}, PC, 32'h0);
        step();
        check({tag, "_boot2_fv"}, {31'b0, FetchValid}, 32'd1);
        check({tag, "_boot2_pc"}, PC, 32'h0);
        idle_inputs();
        step();
        check({tag, "_first_fetch_pc"}, PC, 32'h4);
    endtask

    initial begin
        vecs[0]  = mk("seq_8",        0,0,0,0,0,0,0, 32'h0,         26'h0,  32'h0,         32'h0000_0008);
        vecs[1]  = mk("seq_12",       0,0,0,0,0,0,0, 32'h0,         26'h0,  32'h0,         32'h0000_000C);
        vecs[2]  = mk("seq_16",       0,0,0,0,0,0,0, 32'h0,         26'h0,  32'h0,         32'h0000_0010);
        vecs[3]  = mk("beq_taken",    0,1,0,1,0,0,0, 32'hFFFF_FFFE, 26'h0,  32'h0,         32'h0000_000C);
        vecs[4]  = mk("jr_0x10",      0,0,0,0,0,1,0, 32'h0,         26'h0,  32'h10,        32'h0000_0010);
        vecs[5]  = mk("bne_not",      0,1,1,1,0,0,0, 32'hFFFF_FFFE, 26'h0,  32'h0,         32'h0000_0014);
        vecs[6]  = mk("bne_taken",    0,1,1,0,0,0,0, 32'h3,         26'h0,  32'h0,         32'h0000_0024);
        vecs[7]  = mk("beq_not",      0,1,0,0,0,0,0, 32'h7,         26'h0,  32'h0,         32'h0000_0028);
        vecs[8]  = mk("jr_hi",        0,0,0,0,0,1,0, 32'h0,         26'h0,  32'h4000_0010, 32'h4000_0010);
        vecs[9]  = mk("stall_jump",   1,1,0,1,1,0,0, 32'h5,         26'h10, 32'h0,         32'h4000_0010);
        vecs[10] = mk("jump_over_br", 0,1,0,1,1,0,0, 32'h5,         26'h10, 32'h0,         32'h4000_0040);
        vecs[11] = mk("stall_halt",   1,0,0,0,0,0,1, 32'h0,         26'h0,  32'h0,         32'h4000_0040);
        vecs[12] = mk("jr_top",       0,0,0,0,0,1,0, 32'h0,         26'h0,  32'hFFFF_FFFC, 32'hFFFF_FFFC);
        vecs[13] = mk("wrap",         0,0,0,0,0,0,0, 32'h0,         26'h0,  32'h0,         32'h0000_0000);
        vecs[14] = mk("jr_over_jump", 0,0,0,0,1,1,0, 32'h0,         26'h3,  32'h100,       32'h0000_0100);
        vecs[15] = mk("beq_back_far", 0,1,0,1,0,0,0, 32'hFFFF_FFC0, 26'h0,  32'h0,         32'h0000_0004);
        vecs[16] = mk("jr_0x100",     0,0,0,0,0,1,0, 32'h0,         26'h0,  32'h100,       32'h0000_0100);

        idle_inputs();
        R = 1;
        #12;
        boot_sequence("boot");

        // Sequential stream 0,4,... continues from the first fetch at 4.
        for (int i = 0; i < 17; i++) begin
            Stall = vecs[i].stall; Branch = vecs[i].branch; BranchNe = vecs[i].bne;
            Zero = vecs[i].zero; Jump = vecs[i].jump; JumpReg = vecs[i].jr; Halt = vecs[i].halt;
            Imm = vecs[i].imm; JIndex = vecs[i].jidx; RegTarget = vecs[i].rtgt;
            step();
            check(vecs[i].name, PC, vecs[i].exp_pc);
            check({vecs[i].name, "_plus4"}, PCPlus4, vecs[i].exp_pc + 32'd4);
            check({vecs[i].name, "_fv"}, {31'b0, FetchValid}, 32'd1);
        end

        // Misaligned jr traps: PC holds, sticky flag, halted, frozen thereafter.
        idle_inputs();
        JumpReg = 1; RegTarget = 32'h102;
        step();
        check("jr_mis_pc", PC, 32'h100);
        check("jr_mis_flag", {31'b0, Misaligned}, 32'd1);
        check("jr_mis_halted", {31'b0, Halted}, 32'd1);
        check("jr_mis_fv", {31'b0, FetchValid}, 32'd0);
        for (int k = 0; k < 10; k++) begin
            JumpReg = k[0]; Jump = k[1]; Branch = 1; Zero = 1; RegTarget = 32'h200;
            JIndex = 26'h55; Imm = 32'h8;
            step();
        end
        check("jr_mis_frozen_pc", PC, 32'h100);
        check("jr_mis_frozen_flag", {31'b0, Misaligned}, 32'd1);

        // Async reset mid-cycle takes effect before the next edge.
        idle_inputs();
        #2;
        R = 1;
        #1;
        check("arst1_pc", PC, 32'h0);
        check("arst1_halted", {31'b0, Halted}, 32'd0);
        check("arst1_mis", {31'b0, Misaligned}, 32'd0);
        @(negedge Clk);
        boot_sequence("reboot");

        // Walk to 0x20 and halt there with a competing jump.
        JumpReg = 1; RegTarget = 32'h20;
        step();
        check("to_0x20", PC, 32'h20);
        idle_inputs();
        Halt = 1; Jump = 1; JIndex = 26'h40;
        step();
        check("halt_pc", PC, 32'h20);
        check("halt_flag", {31'b0, Halted}, 32'd1);
        check("halt_fv", {31'b0, FetchValid}, 32'd0);
        check("halt_mis", {31'b0, Misaligned}, 32'd0);
        idle_inputs();
        for (int k = 0; k < 4; k++) step();
        check("halt_hold_pc", PC, 32'h20);
        check("halt_hold_flag", {31'b0, Halted}, 32'd1);

        #3;
        R = 1;
        #1;
        check("arst2_pc", PC, 32'h0);
        check("arst2_halted", {31'b0, Halted}, 32'd0);
        step();
        R = 0;
        step();
        check("post_arst2_pc", PC, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Safety net: never let the run hang.
    initial begin
        #20000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
